// File: rtl/serial_adder_pkg.sv
// serial_adder shared types and limits.
// Imported by the bit-serial adder and its cell.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sa_state_t;

    localparam int SA_MAX_WIDTH = 64;

endpackage

// File: rtl/halfadder.sv
// Half-adder primitive.
// One-bit sum and carry of two inputs.
module halfadder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic co
);

    assign s  = a ^ b;
    assign co = a & b;

endmodule

// File: rtl/serial_adder_fulladder.sv
// Full-adder cell for the bit-serial adder.
// Two chained half adders; either stage may generate the carry.
module fulladder
    import serial_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s0;
    logic c0;
    logic c1;

    halfadder u_ha0 (
        .a  (a),
        .b  (b),
        .s  (s0),
        .co (c0)
    );

    halfadder u_ha1 (
        .a  (s0),
        .b  (ci),
        .s  (s),
        .co (c1)
    );

    assign co = c0 | c1;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder, one bit pair per clock.
// Valid/ready on both sides; result held until accepted.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sa_state_t        state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             co_q, co_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] sum_sh_nx;

    fulladder u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_c)
    );

    // New sum bit enters at the MSB; the word slides right.
    assign sum_sh_nx = WIDTH'({fa_s, sum_sh_q} >> 1);

    // Next-state and datapath updates for the three-phase FSM.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        co_d     = co_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = ci;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_sh_d = sum_sh_nx;
                carry_d  = fa_c;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    sum_d   = sum_sh_nx;
                    co_d    = fa_c;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            co_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            co_q     <= co_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign sum       = sum_q;
    assign co        = co_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8 and WIDTH=1).
// Cycle-level reference model plus directed literal results.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       iv8, ir8, ov8, or8, ci8, co8, bs8;
    logic [7:0] a8, b8, s8;
    logic       iv1, ir1, ov1, or1, ci1, co1, bs1;
    logic [0:0] a1, b1, s1;

    serial_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .ci(ci8),
        .out_valid(ov8), .out_ready(or8),
        .sum(s8), .co(co8), .busy(bs8)
    );

    serial_adder #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .ci(ci1),
        .out_valid(ov1), .out_ready(or1),
        .sum(s1), .co(co1), .busy(bs1)
    );

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    // Reference model: 0 idle, 1 computing, 2 result held.
    // Result = a+b+ci mod 2^(W+1); visible W edges after accept.
    int         m_st[2]   = '{0, 0};
    int         m_wait[2] = '{0, 0};
    logic [8:0] m_exp[2]  = '{9'd0, 9'd0};
    logic [8:0] m_last[2] = '{9'd0, 9'd0};

    task mstep(input int k, input logic v, input logic [7:0] a,
               input logic [7:0] b, input logic ci, input logic rdy,
               input int w);
        logic [8:0] mask;
        mask = (9'd1 << w) - 9'd1;
        case (m_st[k])
            0: if (v) begin
                m_exp[k]  <= ({1'b0, a} & mask) + ({1'b0, b} & mask)
                             + 9'(ci);
                m_wait[k] <= w;
                m_st[k]   <= 1;
            end
            1: begin
                m_wait[k] <= m_wait[k] - 1;
                if (m_wait[k] == 1) begin
                    m_st[k]   <= 2;
                    m_last[k] <= m_exp[k];
                end
            end
            default: if (rdy) m_st[k] <= 0;
        endcase
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_st[k]   <= 0;
                m_wait[k] <= 0;
                m_exp[k]  <= '0;
                m_last[k] <= '0;
            end
        end else begin
            mstep(0, iv8, a8, b8, ci8, or8, 8);
            mstep(1, iv1, {7'd0, a1}, {7'd0, b1}, ci1, or1, 1);
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ir8",   ir8, 64'(m_st[0] == 0));
            chk("busy8", bs8, 64'(m_st[0] == 1));
            chk("ov8",   ov8, 64'(m_st[0] == 2));
            chk("res8",  {co8, s8}, m_last[0]);
            chk("ir1",   ir1, 64'(m_st[1] == 0));
            chk("busy1", bs1, 64'(m_st[1] == 1));
            chk("ov1",   ov1, 64'(m_st[1] == 2));
            chk("res1",  {co1, s1}, m_last[1]);
        end
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic [8:0] exp,
                       input string nm, input bit disturb);
        int n;
        n = 0;
        while (!ir8 && n < 50) begin
            @(posedge clk); #2; n++;
        end
        chk({nm, "_idle"}, ir8, 1);
        iv8 = 1'b1; a8 = a; b8 = b; ci8 = ci;
        @(posedge clk); #2;
        iv8 = 1'b0;
        a8 = ~a; b8 = 8'h5C; ci8 = ~ci;
        if (disturb) begin
            @(posedge clk); #2;
            iv8 = 1'b1; a8 = 8'h11; b8 = 8'hA7;
            @(posedge clk); #2;
            iv8 = 1'b0; b8 = 8'h3E;
        end
        n = 0;
        while (!ov8 && n < 40) begin
            @(posedge clk); #2; n++;
        end
        chk({nm, "_ov"}, ov8, 1);
        chk({nm, "_res"}, {co8, s8}, exp);
        if (or8) begin
            @(posedge clk); #2;
            chk({nm, "_rdy"}, ir8, 1);
        end
    endtask

    task automatic op1(input logic a, input logic b, input logic ci,
                       input logic [1:0] exp, input string nm);
        int n;
        n = 0;
        while (!ir1 && n < 20) begin
            @(posedge clk); #2; n++;
        end
        iv1 = 1'b1; a1 = a; b1 = b; ci1 = ci;
        @(posedge clk); #2;
        iv1 = 1'b0; a1 = ~a; b1 = ~b; ci1 = ~ci;
        chk({nm, "_busy"}, bs1, 1);
        @(posedge clk); #2;
        chk({nm, "_ov"}, ov1, 1);
        chk({nm, "_res"}, {co1, s1}, exp);
    endtask

    int w1_tab[8] = '{0, 1, 1, 2, 1, 2, 2, 3};

    initial begin
        iv8 = 0; a8 = 0; b8 = 0; ci8 = 0; or8 = 1;
        iv1 = 0; a1 = 0; b1 = 0; ci1 = 0; or1 = 1;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ir",  ir8, 1);
        chk("rst_ov",  ov8, 0);
        chk("rst_sum", {co8, s8}, 0);
        rst_n = 1'b1;

        op8(8'h5A, 8'h3C, 1'b0, 9'h096, "a5a_3c", 0);
        op8(8'hFF, 8'h01, 1'b0, 9'h100, "ff_01", 0);
        op8(8'hFF, 8'hFF, 1'b1, 9'h1FF, "ff_ff_c", 0);

        or8 = 1'b0;
        op8(8'h80, 8'h80, 1'b1, 9'h101, "bp", 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            chk("bp_hold_ov", ov8, 1);
            chk("bp_hold_res", {co8, s8}, 9'h101);
            chk("bp_hold_ir", ir8, 0);
        end
        or8 = 1'b1;
        @(posedge clk); #2;
        chk("bp_release", ir8, 1);

        op8(8'h12, 8'h34, 1'b1, 9'h047, "midop", 1);

        @(posedge clk); #2;
        iv8 = 1'b1; a8 = 8'h0F; b8 = 8'h01; ci8 = 1'b0;
        @(posedge clk); #2;
        iv8 = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("pre_rst_busy", bs8, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_ov", ov8, 0);
        chk("arst_ir", ir8, 1);
        chk("arst_busy", bs8, 0);
        chk("arst_res", {co8, s8}, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        op8(8'h01, 8'h01, 1'b0, 9'h002, "post_rst", 0);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            op1(v[2], v[1], v[0], 2'(w1_tab[i]), "w1");
        end

        repeat (3) @(posedge clk);
        #2;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
